// File: rtl/branch_predictor_if.sv
// Pipeline-side bundle for the branch predictor: ID lookup, EXE resolve and statistics.
// The pipeline control holds the master end; the predictor holds the slave end.
interface branch_predictor_if #(
  parameter int STAT_BITS = 16
);
  logic [31:0]          ID_pc;
  logic [1:0]           branch;
  logic [1:0]           ID_EXE_branch;
  logic                 branch_taken;
  logic                 stall;
  logic                 flush;
  logic                 predict_taken;
  logic                 misprediction;
  logic [STAT_BITS-1:0] branch_count;
  logic [STAT_BITS-1:0] mispredict_count;

  modport master (
    output ID_pc, branch, ID_EXE_branch, branch_taken, stall, flush,
    input  predict_taken, misprediction, branch_count, mispredict_count
  );

  modport slave (
    input  ID_pc, branch, ID_EXE_branch, branch_taken, stall, flush,
    output predict_taken, misprediction, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// 2-bit saturating-counter BHT predictor: combinational ID lookup, one-stage EXE tracking,
// resolve/train on the ALU outcome, plus saturating branch and misprediction statistics.
module branch_predictor #(
  parameter int INDEX_BITS = 4,
  parameter int STAT_BITS  = 16
) (
  input logic             clk,
  input logic             rst_n,
  branch_predictor_if.slave bp
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [INDEX_BITS-1:0] idx;
  logic                  is_cond;
  logic                  resolve;
  logic                  unused_pc_bits;

  logic [1:0]            bht_q [ENTRIES];
  logic                  exe_valid_q, exe_valid_d;
  logic                  exe_pred_q, exe_pred_d;
  logic [INDEX_BITS-1:0] exe_idx_q, exe_idx_d;
  logic [1:0]            bht_upd_d;
  logic [STAT_BITS-1:0]  branch_count_q, branch_count_d;
  logic [STAT_BITS-1:0]  mispredict_count_q, mispredict_count_d;

  function automatic logic [1:0] train(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == 2'b11) ? cnt : cnt + 2'd1;
    else       return (cnt == 2'b00) ? cnt : cnt - 2'd1;
  endfunction

  function automatic logic [STAT_BITS-1:0] stat_inc(input logic [STAT_BITS-1:0] v);
    return (&v) ? v : v + {{(STAT_BITS-1){1'b0}}, 1'b1};
  endfunction

  // Word-aligned PCs: drop the byte offset before indexing.
  assign idx            = bp.ID_pc[INDEX_BITS+1:2];
  assign unused_pc_bits = ^{bp.ID_pc[31:INDEX_BITS+2], bp.ID_pc[1:0]};
  assign is_cond        = (bp.branch == 2'b01);

  assign bp.predict_taken    = is_cond & bht_q[idx][1];
  assign resolve             = exe_valid_q & (bp.ID_EXE_branch == 2'b01);
  assign bp.misprediction    = resolve & (bp.branch_taken != exe_pred_q);
  assign bp.branch_count     = branch_count_q;
  assign bp.mispredict_count = mispredict_count_q;

  always_comb begin
    exe_valid_d        = 1'b0;
    exe_pred_d         = exe_pred_q;
    exe_idx_d          = exe_idx_q;
    bht_upd_d          = train(bht_q[exe_idx_q], bp.branch_taken);
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (!(bp.stall | bp.flush)) begin
      exe_valid_d = is_cond;
      exe_pred_d  = bp.predict_taken;
      exe_idx_d   = idx;
    end
    if (resolve) begin
      branch_count_d = stat_inc(branch_count_q);
      if (bp.misprediction) mispredict_count_d = stat_inc(mispredict_count_q);
    end
  end

  // Training writes land after the edge, so a same-index lookup in ID sees the old count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= 2'b01;
      exe_valid_q        <= 1'b0;
      exe_pred_q         <= 1'b0;
      exe_idx_q          <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      exe_valid_q        <= exe_valid_d;
      exe_pred_q         <= exe_pred_d;
      exe_idx_q          <= exe_idx_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
      if (resolve) bht_q[exe_idx_q] <= bht_upd_d;
    end
  end

endmodule
